pong_sound_engine: RTL and testbench

Parametrised multi-channel sound-effect generator for the Pong game top level; next generation of the single-tone Speaker logic. Each of NUM_CHANNELS channels is triggered by a one-cycle game event (paddle hit, wall bounce, score, ...). Each channel plays a square wave of programmable half-period for a programmable number of milliseconds. A fixed-priority mixer drives the single Speaker pin, and a global Mute is provided.

---
 rtl/pong_sound_engine.sv | 144 ++++++++++++++
 tb/tb_pong_sound_engine.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_sound_engine.sv
// -----------------------------------------------------------------------------
// pong_sound_engine
//   Multi-channel sound-effect generator for the Pong top level. Each channel
//   is started by a one-cycle game event and plays a 50% duty square wave of a
//   programmable half-period for a programmable number of milliseconds. A
//   fixed-priority mixer (channel 0 highest) drives the single speaker pin.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_trigger      [NUM_CHANNELS]            load/start channel i
//   i_half_period  [NUM_CHANNELS*HPW]        channel i at [i*HPW +: HPW], cycles
//   i_duration     [NUM_CHANNELS*DW]         channel i at [i*DW +: DW], ms
//   i_mute         forces the speaker low, channels keep running
//   o_busy         [NUM_CHANNELS] registered channel-active vector
//   o_speaker      registered square-wave output
// -----------------------------------------------------------------------------
module pong_sound_engine #(
    parameter int NUM_CHANNELS      = 4,
    parameter int CLOCK_FREQ_HZ     = 100000000,
    parameter int HALF_PERIOD_WIDTH = 18,
    parameter int DURATION_WIDTH    = 10
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic [NUM_CHANNELS-1:0]                   i_trigger,
    input  logic [NUM_CHANNELS*HALF_PERIOD_WIDTH-1:0] i_half_period,
    input  logic [NUM_CHANNELS*DURATION_WIDTH-1:0]    i_duration,
    input  logic                                      i_mute,
    output logic [NUM_CHANNELS-1:0]                   o_busy,
    output logic                                      o_speaker
);

    localparam int HPW   = HALF_PERIOD_WIDTH;
    localparam int DW    = DURATION_WIDTH;
    localparam int TICKS = CLOCK_FREQ_HZ / 1000;
    localparam int PW    = (TICKS > 1) ? $clog2(TICKS) : 1;

    // ------------------------------------------------------------------
    // Millisecond prescaler: free-running, shared, never restarted.
    // ------------------------------------------------------------------
    logic [PW-1:0] r_pre;
    logic          w_ms_tick;

    assign w_ms_tick = (r_pre == PW'(TICKS - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pre <= '0;
        end else if (w_ms_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Tone channels
    // ------------------------------------------------------------------
    logic [NUM_CHANNELS-1:0] w_active;
    logic [NUM_CHANNELS-1:0] w_wave;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        logic [HPW-1:0] r_hp;
        logic [DW-1:0]  r_dur;
        logic [HPW-1:0] r_phase;
        logic           r_wave;
        logic           r_active;
        logic [HPW-1:0] w_hp_in;
        logic [DW-1:0]  w_dur_in;

        assign w_hp_in  = i_half_period[g*HPW +: HPW];
        assign w_dur_in = i_duration[g*DW +: DW];

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_hp     <= '0;
                r_dur    <= '0;
                r_phase  <= '0;
                r_wave   <= 1'b0;
                r_active <= 1'b0;
            end else if (i_trigger[g]) begin
                // A trigger always wins; a zero field turns it into a stop.
                r_hp    <= w_hp_in;
                r_dur   <= w_dur_in;
                r_phase <= '0;
                if (w_hp_in != '0 && w_dur_in != '0) begin
                    r_active <= 1'b1;
                    r_wave   <= 1'b1;
                end else begin
                    r_active <= 1'b0;
                    r_wave   <= 1'b0;
                end
            end else if (r_active) begin
                if (w_ms_tick && r_dur == DW'(1)) begin
                    r_active <= 1'b0;
                    r_wave   <= 1'b0;
                    r_phase  <= '0;
                    r_dur    <= '0;
                end else begin
                    if (w_ms_tick) begin
                        r_dur <= r_dur - 1'b1;
                    end
                    if (r_phase == r_hp - HPW'(1)) begin
                        r_phase <= '0;
                        r_wave  <= ~r_wave;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
            end
        end

        assign w_active[g] = r_active;
        assign w_wave[g]   = r_wave;
    end

    // ------------------------------------------------------------------
    // Fixed-priority mixer. Scanning from the top down leaves the lowest
    // active index as the winner; idle channels hold wave=0, so no active
    // channel yields silence.
    // ------------------------------------------------------------------
    logic w_sel_wave;

    always_comb begin
        w_sel_wave = 1'b0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_sel_wave = w_wave[i];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_speaker <= 1'b0;
            o_busy    <= '0;
        end else begin
            o_speaker <= i_mute ? 1'b0 : w_sel_wave;
            o_busy    <= w_active;
        end
    end

endmodule

// File: tb/tb_pong_sound_engine.sv
// -----------------------------------------------------------------------------
// tb_pong_sound_engine
//   Directed bench for pong_sound_engine at 10 clock cycles per millisecond.
//   A free-running edge counter mirrors the prescaler phase so that the end
//   of each tone can be predicted exactly from the trigger edge.
// -----------------------------------------------------------------------------
module tb_pong_sound_engine;

    localparam int NCH = 4;
    localparam int HPW = 18;
    localparam int DW  = 10;

    logic               clk;
    logic               rst;
    logic [NCH-1:0]     trig;
    logic [NCH*HPW-1:0] hp;
    logic [NCH*DW-1:0]  dur;
    logic               mute;
    logic [NCH-1:0]     busy;
    logic               spk;

    int n_cmp = 0;
    int n_err = 0;
    int ecnt  = 0;   // rising edges since reset release

    pong_sound_engine #(
        .NUM_CHANNELS     (NCH),
        .CLOCK_FREQ_HZ    (10000),
        .HALF_PERIOD_WIDTH(HPW),
        .DURATION_WIDTH   (DW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_trigger    (trig),
        .i_half_period(hp),
        .i_duration   (dur),
        .i_mute       (mute),
        .o_busy       (busy),
        .o_speaker    (spk)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, ecnt);
        end
    endtask

    // Edge at which a tone triggered at edge k with duration d ms goes idle:
    // ticks land on edges that are multiples of 10; the one at k is overridden.
    function automatic int end_edge(input int k, input int d);
        return ((k / 10) + 1) * 10 + 10 * (d - 1);
    endfunction

    // Channel wave value after edge e, for a tone triggered at edge k.
    function automatic logic sq(input int e, input int k, input int h);
        return (((e - k) / h) % 2) == 0;
    endfunction

    initial begin
        int k, k2, k0, ka, e, m, s;
        logic a, muted;

        // ---------------- reset with random inputs ----------------
        rst  = 1'b0;
        trig = NCH'($urandom);
        mute = 1'($urandom);
        for (int i = 0; i < NCH; i++) begin
            hp[i*HPW +: HPW] = HPW'($urandom);
            dur[i*DW +: DW]  = DW'($urandom);
        end
        #17 rst = 1'b1;
        #1;
        chk("rst_spk_immediate", spk, 0);
        chk("rst_busy_immediate", busy, 0);
        step(5);
        chk("rst_spk_hold", spk, 0);
        chk("rst_busy_hold", busy, 0);
        trig = '0; mute = 1'b0; hp = '0; dur = '0;
        rst  = 1'b0;
        step(3);
        chk("idle_spk", spk, 0);
        chk("idle_busy", busy, 0);

        // ---------------- single tone ch0 HP=5 Dur=3 ----------------
        trig = 4'b0001; hp[0 +: HPW] = 18'd5; dur[0 +: DW] = 10'd3;
        step(1);
        k = ecnt;
        trig = '0;
        for (int i = 0; i < NCH; i++) hp[i*HPW +: HPW] = HPW'($urandom);  // ignored now
        chk("tone_busy_latency", busy, 0);
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("tone_spk", spk, ((i / 5) % 2) == 0);
            chk("tone_busy", busy, 4'b0001);
        end
        e = end_edge(k, 3);
        while (ecnt < e) step(1);
        chk("tone_busy_last", busy, 4'b0001);
        step(1);
        chk("tone_busy_end", busy, 0);
        chk("tone_spk_end", spk, 0);

        // ---------------- priority ch2 under ch0 ----------------
        trig = 4'b0100; hp[2*HPW +: HPW] = 18'd3; dur[2*DW +: DW] = 10'd20;
        step(1);
        k2 = ecnt;
        trig = '0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("prio_ch2_spk", spk, sq(ecnt - 1, k2, 3));
            chk("prio_ch2_busy", busy, 4'b0100);
        end
        trig = 4'b0001; hp[0 +: HPW] = 18'd7; dur[0 +: DW] = 10'd2;
        step(1);
        k0 = ecnt;
        trig = '0;
        chk("prio_trig_edge_spk", spk, sq(k0 - 1, k2, 3));
        e = end_edge(k0, 2);
        for (int i = 0; i < e - k0 + 12; i++) begin
            step(1);
            s = ecnt;
            a = (s - 1 < e);
            chk("prio_spk", spk, a ? sq(s - 1, k0, 7) : sq(s - 1, k2, 3));
            chk("prio_busy", busy, a ? 4'b0101 : 4'b0100);
        end

        // ---------------- stop ch2 with Dur=0 ----------------
        trig = 4'b0100; hp[2*HPW +: HPW] = 18'd3; dur[2*DW +: DW] = 10'd0;
        step(1);
        trig = '0;
        chk("stop_busy_edge1", busy, 4'b0100);
        step(1);
        chk("stop_busy", busy, 0);
        chk("stop_spk", spk, 0);

        // ---------------- retrigger ch1 HP=4 Dur=2 ----------------
        while (ecnt % 10 != 0) step(1);
        trig = 4'b0010; hp[1*HPW +: HPW] = 18'd4; dur[1*DW +: DW] = 10'd2;
        step(1);
        ka = ecnt;
        trig = '0;
        for (int i = 0; i < 14; i++) begin
            step(1);
            chk("retrig_first_spk", spk, sq(ecnt - 1, ka, 4));
            chk("retrig_first_busy", busy, 4'b0010);
        end
        trig = 4'b0010;
        step(1);
        k = ecnt;
        trig = '0;
        chk("retrig_edge_spk", spk, sq(k - 1, ka, 4));
        e = end_edge(k, 2);
        for (int i = 0; i < e - k + 2; i++) begin
            step(1);
            s = ecnt;
            a = (s - 1 < e);
            chk("retrig_spk", spk, a ? sq(s - 1, k, 4) : 1'b0);
            chk("retrig_busy", busy, a ? 4'b0010 : 4'b0000);
        end

        // ---------------- mute over ch3 HP=2 Dur=3 ----------------
        trig = 4'b1000; hp[3*HPW +: HPW] = 18'd2; dur[3*DW +: DW] = 10'd3;
        step(1);
        k = ecnt;
        trig = '0;
        e = end_edge(k, 3);
        m = k + 4;
        for (int i = 0; i < e - k + 2; i++) begin
            if (ecnt == m)     mute = 1'b1;
            if (ecnt == m + 8) mute = 1'b0;
            step(1);
            s = ecnt;
            muted = (s >= m + 1) && (s <= m + 8);
            a = (s - 1 < e);
            chk("mute_spk", spk, muted ? 1'b0 : (a ? sq(s - 1, k, 2) : 1'b0));
            chk("mute_busy", busy, a ? 4'b1000 : 4'b0000);
        end

        // ---------------- HP=1 Dur=1 on ch0 ----------------
        trig = 4'b0001; hp[0 +: HPW] = 18'd1; dur[0 +: DW] = 10'd1;
        step(1);
        k = ecnt;
        trig = '0;
        e = end_edge(k, 1);
        for (int i = 0; i < e - k + 2; i++) begin
            step(1);
            s = ecnt;
            a = (s - 1 < e);
            chk("hp1_spk", spk, a ? sq(s - 1, k, 1) : 1'b0);
            chk("hp1_busy", busy, a ? 4'b0001 : 4'b0000);
        end

        // ---------------- async reset mid-tone ----------------
        trig = 4'b0001; hp[0 +: HPW] = 18'd5; dur[0 +: DW] = 10'd5;
        step(1);
        trig = '0;
        step(2);
        chk("arst_pre_spk", spk, 1);
        chk("arst_pre_busy", busy, 4'b0001);
        #2 rst = 1'b1;
        #1;
        chk("arst_spk", spk, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(3);
        chk("arst_after_spk", spk, 0);
        chk("arst_after_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
